// File: rtl/pipe_bus_ctrl.sv
// Pipeline stall generator and IF/MEM arbiter for the single external memory bus.
// Bus wait states, timeouts and ID/EX stall requests become per-stage stall bits.
module pipe_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [5:0]  stall,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds *_req high until it sees its *_done pulse;
  // done is a single-cycle completion (ack or timeout), after which req may drop.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IF   = 2'd1,
    S_MEM  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_wcnt;
  logic        w_xfer;
  logic        w_tmo;

  assign w_xfer = (r_state == S_IF) || (r_state == S_MEM);
  assign w_tmo  = w_xfer && !bus_ack && (r_wcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wcnt <= 8'd0;
          if (mem_req)
            r_state <= S_MEM;
          else if (if_req)
            r_state <= S_IF;
        end
        S_IF, S_MEM: begin
          if (bus_ack || w_tmo)
            r_state <= S_IDLE;
          else
            r_wcnt <= r_wcnt + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Everything below is combinational from state, requests and bus_ack;
  // reset masks every output so downstream registers see no stall or pulse.
  always_comb begin
    if_done   = 1'b0;
    if_rdata  = 32'd0;
    mem_done  = 1'b0;
    mem_rdata = 32'd0;
    bus_err   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_sel   = 4'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    stall     = 6'b000000;
    dbg_state = 2'd0;
    if (!rst) begin
      dbg_state = r_state;
      if (r_state == S_MEM) begin
        bus_req   = 1'b1;
        bus_we    = mem_we;
        bus_sel   = mem_sel;
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        mem_done  = bus_ack || w_tmo;
        mem_rdata = bus_ack ? bus_rdata : 32'd0;
      end else if (r_state == S_IF) begin
        bus_req   = 1'b1;
        bus_sel   = 4'b1111;
        bus_addr  = if_addr;
        if_done   = bus_ack || w_tmo;
        if_rdata  = bus_ack ? bus_rdata : 32'd0;
      end
      bus_err = w_tmo;

      if (mem_req && !mem_done)
        stall = 6'b011111;
      else if (stallreq_ex)
        stall = 6'b001111;
      else if (stallreq_id)
        stall = 6'b000111;
      else if (if_req && !if_done)
        stall = 6'b000011;
    end
  end

endmodule

// File: tb/tb_pipe_bus_ctrl.sv
// Bench for pipe_bus_ctrl: directed scenarios plus randomized transactions,
// with expectations derived from cycle-level timing rules of the bus protocol.
module tb_pipe_bus_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        bus_err, bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [5:0]  stall;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;
  logic [31:0] exp_q[$];

  pipe_bus_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .stall(stall), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    stallreq_id = 0; stallreq_ex = 0;
    if_req = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;
    bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    if_req = 1; mem_req = 1; stallreq_id = 1; stallreq_ex = 1; bus_ack = 1;
    bus_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (stall !== 6'b0) begin n_fail++; $display("FAIL reset_stall c%0d got %b exp %b", c, stall, 6'b0); end
      n_cmp++;
      if ({bus_req, if_done, mem_done, bus_err} !== 4'b0) begin
        n_fail++; $display("FAIL reset_outs c%0d got %b exp 0000", c, {bus_req, if_done, mem_done, bus_err});
      end
    end
    @(posedge clk); #1;
    rst = 0; drive_idle();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    n_cmp++;
    if (stall !== 6'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got stall=%b bus_req=%b exp 000000/0", stall, bus_req);
    end
  endtask

  // One IF and/or MEM transaction. Timeline by cycle t: requests at t=0, MEM
  // (priority) owns t=1..lm, one idle cycle, then IF owns si..fi. A transfer
  // with w waits lasts w+1 cycles, capped at TMO when it times out.
  task automatic run_scenario(input string name, input bit has_if, input bit has_mem,
                              input logic [31:0] ia, input logic [31:0] id,
                              input logic mwe, input logic [3:0] msel,
                              input logic [31:0] ma, input logic [31:0] mwd,
                              input logic [31:0] md, input int wi, input int wm,
                              input bit rand_sr);
    int lm, li, si, fi, tend;
    bit m_act, i_act, e_md, e_id, mreq_v, ireq_v, ack, e_err;
    logic [5:0]  e_stall;
    logic [31:0] e_addr, e_wdata, e_mrd, e_ird, got;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [1:0]  e_state;
    lm = has_mem ? ((wm < TMO) ? wm + 1 : TMO) : 0;
    li = has_if  ? ((wi < TMO) ? wi + 1 : TMO) : 0;
    si = has_mem ? lm + 2 : 1;
    fi = si + li - 1;
    tend = has_if ? fi + 1 : lm + 1;
    if (has_mem) exp_q.push_back((wm < TMO) ? md : 32'd0);
    if (has_if)  exp_q.push_back((wi < TMO) ? id : 32'd0);
    for (int t = 0; t <= tend; t++) begin
      @(posedge clk); #1;
      m_act  = has_mem && t >= 1 && t <= lm;
      i_act  = has_if && t >= si && t <= fi;
      e_md   = has_mem && t == lm;
      e_id   = has_if && t == fi;
      mreq_v = has_mem && t <= lm;
      ireq_v = has_if && t <= fi;
      ack    = (m_act && (t - 1) == wm) || (i_act && (t - si) == wi);
      mem_req = mreq_v; mem_we = mwe; mem_sel = msel; mem_addr = ma; mem_wdata = mwd;
      if_req = ireq_v; if_addr = ia;
      bus_ack = ack;
      bus_rdata = ack ? (m_act ? md : id) : $urandom();
      stallreq_ex = rand_sr ? 1'($urandom_range(0, 1)) : 1'b0;
      stallreq_id = rand_sr ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (mreq_v && !e_md)      e_stall = 6'b011111;
      else if (stallreq_ex)     e_stall = 6'b001111;
      else if (stallreq_id)     e_stall = 6'b000111;
      else if (ireq_v && !e_id) e_stall = 6'b000011;
      else                      e_stall = 6'b000000;
      e_addr  = m_act ? ma : (i_act ? ia : 32'd0);
      e_sel   = m_act ? msel : (i_act ? 4'hF : 4'h0);
      e_we    = m_act ? mwe : 1'b0;
      e_wdata = m_act ? mwd : 32'd0;
      e_err   = (e_md && wm >= TMO) || (e_id && wi >= TMO);
      e_mrd   = (e_md && wm < TMO) ? md : 32'd0;
      e_ird   = (e_id && wi < TMO) ? id : 32'd0;
      e_state = m_act ? 2'd2 : (i_act ? 2'd1 : 2'd0);
      n_cmp++;
      if (stall !== e_stall) begin n_fail++; $display("FAIL %s stall t%0d got %b exp %b", name, t, stall, e_stall); end
      n_cmp++;
      if (bus_req !== (m_act || i_act)) begin n_fail++; $display("FAIL %s bus_req t%0d got %b exp %b", name, t, bus_req, m_act || i_act); end
      n_cmp++;
      if ({bus_we, bus_sel, bus_addr, bus_wdata} !== {e_we, e_sel, e_addr, e_wdata}) begin
        n_fail++; $display("FAIL %s bus_fields t%0d got we=%b sel=%h a=%h d=%h exp we=%b sel=%h a=%h d=%h",
                           name, t, bus_we, bus_sel, bus_addr, bus_wdata, e_we, e_sel, e_addr, e_wdata);
      end
      n_cmp++;
      if ({mem_done, if_done, bus_err} !== {e_md, e_id, e_err}) begin
        n_fail++; $display("FAIL %s done_err t%0d got md=%b id=%b err=%b exp md=%b id=%b err=%b",
                           name, t, mem_done, if_done, bus_err, e_md, e_id, e_err);
      end
      n_cmp++;
      if (mem_rdata !== e_mrd || if_rdata !== e_ird) begin
        n_fail++; $display("FAIL %s rdata t%0d got m=%h i=%h exp m=%h i=%h", name, t, mem_rdata, if_rdata, e_mrd, e_ird);
      end
      n_cmp++;
      if (dbg_state !== e_state) begin n_fail++; $display("FAIL %s state t%0d got %0d exp %0d", name, t, dbg_state, e_state); end
      // scoreboard: completions must arrive in grant order with the right data
      if (mem_done === 1'b1 || if_done === 1'b1) begin
        got = (mem_done === 1'b1) ? mem_rdata : if_rdata;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s sb_extra t%0d got %h exp none", name, t, got);
        end else begin
          e_mrd = exp_q.pop_front();
          if (got !== e_mrd) begin n_fail++; $display("FAIL %s sb_data t%0d got %h exp %h", name, t, got, e_mrd); end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s sb_missing got %0d left exp 0", name, exp_q.size());
      exp_q.delete();
    end
    drive_idle();
  endtask

  task automatic test_single_fetch();
    run_scenario("single_fetch", 1, 0, 32'h00000100, 32'h3C011234,
                 0, 4'h0, 32'h0, 32'h0, 32'h0, 2, 0, 0);
  endtask

  task automatic test_collision();
    run_scenario("collision", 1, 1, 32'h00000104, 32'h24420001,
                 0, 4'hF, 32'h00000080, 32'h0, 32'hCAFEF00D, 0, 0, 0);
  endtask

  task automatic test_timeout();
    run_scenario("timeout", 0, 1, 32'h0, 32'h0,
                 1, 4'b0011, 32'h00000200, 32'h5555AAAA, 32'h12345678, 0, 100, 0);
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h40; stallreq_ex = 1; stallreq_id = 1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 6'b001111) begin n_fail++; $display("FAIL prio_ex got %b exp %b", stall, 6'b001111); end
    @(posedge clk); #1;
    stallreq_ex = 0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 6'b000111) begin n_fail++; $display("FAIL prio_id got %b exp %b", stall, 6'b000111); end
    @(posedge clk); #1;
    stallreq_id = 0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 6'b000011) begin n_fail++; $display("FAIL prio_if got %b exp %b", stall, 6'b000011); end
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    n_cmp++;
    if (if_done !== 1'b1 || if_rdata !== 32'h0BADF00D || stall !== 6'b0) begin
      n_fail++; $display("FAIL prio_done got done=%b rd=%h stall=%b exp 1/0badf00d/000000", if_done, if_rdata, stall);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle got state=%0d bus_req=%b exp 0/0", dbg_state, bus_req);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h00000300;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h00000300) begin
      n_fail++; $display("FAIL rstmid_wait1 got req=%b a=%h exp 1/00000300", bus_req, bus_addr);
    end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({bus_req, if_done, bus_err} !== 3'b000 || stall !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_abort got req=%b done=%b err=%b stall=%b exp 0/0/0/000000", bus_req, if_done, bus_err, stall);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0 || bus_req !== 1'b0 || if_done !== 1'b0 || stall !== 6'b000011) begin
      n_fail++; $display("FAIL rstmid_release got state=%0d req=%b done=%b stall=%b exp 0/0/0/000011", dbg_state, bus_req, if_done, stall);
    end
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'h8C220004;
    @(negedge clk);
    n_cmp++;
    if (bus_req !== 1'b1 || if_done !== 1'b1 || if_rdata !== 32'h8C220004 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_regrant got req=%b done=%b rd=%h err=%b exp 1/1/8c220004/0", bus_req, if_done, if_rdata, bus_err);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstmid_idle got %0d exp 0", dbg_state); end
  endtask

  task automatic test_random();
    bit hi, hm;
    for (int k = 0; k < 40; k++) begin
      hi = 1'($urandom_range(0, 1));
      hm = 1'($urandom_range(0, 1));
      if (!hi && !hm) hi = 1;
      run_scenario("random", hi, hm, $urandom(), $urandom(),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom(), $urandom(), $urandom(),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single_fetch();
    test_collision();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_bus_ctrl.md
# pipe_bus_ctrl

Pipeline control and shared-bus arbiter for the five-stage core. It produces the six-bit `stall` vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also arbitrates the single external memory bus between instruction fetch (IF) and data access (MEM). Bus wait states, bus timeouts and ID/EX stall requests all become stage-accurate stalls and bubbles.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles a granted transfer waits for `bus_ack` before it is aborted. Range 1..255.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `stallreq_id` input 1: ID stage requests a stall (load-use hazard).
- `stallreq_ex` input 1: EX stage requests a stall (multi-cycle madd/msub/div).
- `if_req` input 1: IF requests an instruction fetch; held until `if_done`.
- `if_addr` input 32: fetch address.
- `if_done` output 1: fetch completes this cycle.
- `if_rdata` output 32: fetched word; valid when `if_done`.
- `mem_req` input 1: MEM requests a data access; held until `mem_done`.
- `mem_we` input 1: data write enable.
- `mem_sel` input 4: byte lane select.
- `mem_addr` input 32: data address.
- `mem_wdata` input 32: data write value.
- `mem_done` output 1: data access completes this cycle.
- `mem_rdata` output 32: load data; valid when `mem_done`.
- `bus_err` output 1: one-cycle pulse; the current transfer timed out.
- `bus_req` output 1: transfer active on the external bus.
- `bus_we` output 1: external bus write enable.
- `bus_sel` output 4: external bus byte lane select.
- `bus_addr` output 32: external bus address.
- `bus_wdata` output 32: external bus write data.
- `bus_ack` input 1: bus completes the transfer this cycle.
- `bus_rdata` input 32: bus read data; valid when `bus_ack`.
- `stall` output 6: per-stage hold. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. 1 = hold.

## Operation
- State machine: IDLE, IF_XFER, MEM_XFER. The wait counter `wcnt` is 8 bits.
- IDLE:
  - If `mem_req`, go to MEM_XFER.
  - Otherwise, if `if_req`, go to IF_XFER.
  - MEM has fixed priority on a simultaneous request. IF cannot starve, because MEM is stalled only while its own request is pending.
  - `wcnt` is cleared on every grant.
- IF_XFER / MEM_XFER:
  - `bus_req` = 1.
  - `bus_addr`, `bus_we`, `bus_sel` and `bus_wdata` are driven combinationally from the owner's inputs.
  - For an IF owner: `bus_we` = 0, `bus_sel` = 4'b1111, `bus_wdata` = 0.
- On `bus_ack` during a transfer:
  - The owner's done signal = 1 and its rdata = `bus_rdata` (combinational, same cycle).
  - Next state is IDLE.
- Without ack: `wcnt` increments each cycle.
- Timeout: if `wcnt` == `TIMEOUT`-1 and there is no ack that cycle:
  - `bus_err` = 1 and the owner's done = 1, with rdata = 0.
  - Next state is IDLE.
- Outside a transfer, both done signals = 0, both rdata = 0 and all `bus_*` outputs = 0.
- Stall vector: combinational, highest-priority source wins.
  - `mem_req` && !`mem_done` gives 6'b011111.
  - Else `stallreq_ex` gives 6'b001111.
  - Else `stallreq_id` gives 6'b000111.
  - Else `if_req` && !`if_done` gives 6'b000011.
  - Else 6'b000000.
- Bubble rule for the downstream registers: a stage register inserts a NOP when `stall[k]` = 1 and `stall[k+1]` = 0. It holds when both are 1.
- Reset:
  - State goes to IDLE and `wcnt` to 0.
  - While `rst` = 1, all outputs are forced to 0, including `stall` = 0 and `bus_req` = 0.
  - Asserting `rst` mid-transfer abandons the transfer without a done or err pulse.

## Timing
- A request sampled in cycle N in IDLE gives `bus_req` = 1 from cycle N+1.
- A zero-wait ack in N+1 gives done in N+1. `stall` is high in N and low in N+1.
- Minimum transfer latency is 2 cycles. With W wait cycles, done arrives in cycle N+1+W.
- There is always at least one IDLE cycle between transfers. An IF request that is pending while MEM owns the bus is granted in the cycle after MEM's done.
- Timeout: with no ack, `bus_err` and done pulse in cycle N+`TIMEOUT`.
- `stall`, done and rdata are combinational from state, requests and `bus_ack`. There is no registered output path except the state.

## Test plan
- Reset: `rst` = 1 for 2 cycles with all requests high → `stall` = 0, `bus_req` = 0, state IDLE after release.
- Single fetch: `if_req` with `if_addr` = 0x00000100; bus acks 2 cycles after `bus_req`, with `bus_rdata` = 0x3C011234 → `stall` = 6'b000011 for 3 cycles. Then `if_done` = 1 with `if_rdata` = 0x3C011234, and `stall` = 0 in the same cycle.
- Collision: `if_req` and `mem_req` (load, `mem_addr` = 0x80) in the same cycle, zero-wait bus → MEM is granted first with `stall` = 6'b011111. The IF grant starts in the cycle after `mem_done`, and `if_done` arrives 2 cycles later.
- Priority: `stallreq_ex` and `stallreq_id` both high with a fetch pending → `stall` = 6'b001111. Dropping `stallreq_ex` → 6'b000111.
- Timeout: `TIMEOUT` = 4, MEM store, never acked → `bus_req` high for 4 cycles. In the 4th cycle `bus_err` = `mem_done` = 1 and `mem_rdata` = 0. The next cycle is IDLE.
- Reset mid-operation: assert `rst` in the 2nd wait cycle of a fetch → `bus_req` = 0 next cycle, with no `if_done` or `bus_err` pulse. A re-issued `if_req` after release is granted normally.
